mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_pkg.sv | 15 +
 rtl/mem_bus_arbiter_timeout_cnt.sv | 28 ++
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the data-memory/peripheral bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_LDR  = 1'b1;

  localparam logic [3:0] DEF_UART_NIB = 4'h1;

endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// Bus wait-state counter: clears at the start of a transaction, counts
// stalled BUS cycles and flags when the count reaches LIMIT.
module bus_timeout_cnt #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt;

  assign expired = (cnt == LIMIT);

  // Saturates at LIMIT so a held stall can never wrap back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between the core load/store port and the UART loader,
// running one valid/ready bus transaction at a time with timeout error.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter logic [3:0]  UART_NIB = DEF_UART_NIB,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic              core_err,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic              ldr_err,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_sel,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              owner
);

  state_t            state;
  logic              owner_q;
  logic              last_owner;
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              any_req;
  logic              grant_owner;
  logic              cnt_clr;
  logic              cnt_en;
  logic              expired;

  assign any_req = core_req || ldr_req;

  // On a tie the requester not served last wins.
  always_comb begin
    grant_owner = OWN_CORE;
    if (core_req && ldr_req) begin
      grant_owner = (last_owner == OWN_CORE) ? OWN_LDR : OWN_CORE;
    end else if (ldr_req) begin
      grant_owner = OWN_LDR;
    end
  end

  assign cnt_clr = (state == IDLE) && any_req;
  assign cnt_en  = (state == BUS) && !bus_ready;

  bus_timeout_cnt #(
    .LIMIT(8'(TIMEOUT))
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner_q    <= OWN_CORE;
      last_owner <= OWN_LDR;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= BUS;
            owner_q <= grant_owner;
            if (grant_owner == OWN_LDR) begin
              we_q    <= ldr_we;
              addr_q  <= ldr_addr;
              wdata_q <= ldr_wdata;
            end else begin
              we_q    <= core_we;
              addr_q  <= core_addr;
              wdata_q <= core_wdata;
            end
          end
        end
        BUS: begin
          // Ready takes priority over a timeout landing in the same cycle.
          if (bus_ready) begin
            if (!we_q) begin
              rdata_q <= bus_rdata;
            end
            err_q <= 1'b0;
            state <= RESP;
          end else if (expired) begin
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          last_owner <= owner_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_valid = (state == BUS);
  assign bus_we    = bus_valid && we_q;
  assign bus_sel   = bus_valid && (addr_q[ADDR_W-1 -: 4] == UART_NIB);
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign owner     = owner_q;
  assign rdata     = rdata_q;

  assign core_ack  = (state == RESP) && (owner_q == OWN_CORE);
  assign ldr_ack   = (state == RESP) && (owner_q == OWN_LDR);
  assign core_err  = core_ack && err_q;
  assign ldr_err   = ldr_ack && err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions push expected
// bus/ack results, a monitor compares them as the DUT presents them.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        core_req, core_we, ldr_req, ldr_we;
  logic [31:0] core_addr, core_wdata, ldr_addr, ldr_wdata;
  logic        core_ack, core_err, ldr_ack, ldr_err;
  logic [31:0] rdata;
  logic        bus_valid, bus_we, bus_sel, bus_ready, owner;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  mem_bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .UART_NIB(4'h1),
    .TIMEOUT (255)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .core_req  (core_req),
    .core_we   (core_we),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_ack  (core_ack),
    .core_err  (core_err),
    .ldr_req   (ldr_req),
    .ldr_we    (ldr_we),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_ack   (ldr_ack),
    .ldr_err   (ldr_err),
    .rdata     (rdata),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_sel   (bus_sel),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata),
    .owner     (owner)
  );

  typedef struct {
    logic        who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;
    logic        err;
    int          ack_cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ws = 0;
  int          bcnt = 0;
  logic [31:0] slv_rdata = '0;
  logic [31:0] model_rdata = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave: raise ready after ws stalled BUS cycles.
  always @(negedge clk) begin
    if (bus_valid) begin
      bus_ready = (bcnt == ws);
      bus_rdata = slv_rdata;
      bcnt++;
    end else begin
      bus_ready = 1'b0;
      bcnt = 0;
    end
  end

  // Monitor: checks bus contents every BUS cycle, pops on ack.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_valid) begin
        if (q.size() == 0) begin
          check("unexpected_bus_valid", 64'(bus_valid), 64'(0));
        end else begin
          check("bus_addr", 64'(bus_addr), 64'(q[0].addr));
          check("bus_we", 64'(bus_we), 64'(q[0].we));
          check("bus_sel", 64'(bus_sel), 64'(q[0].sel));
          check("owner", 64'(owner), 64'(q[0].who));
          if (q[0].we) check("bus_wdata", 64'(bus_wdata), 64'(q[0].wdata));
        end
      end
      if (core_ack || ldr_ack) begin
        if (q.size() == 0) begin
          check("unexpected_ack", {62'(0), core_ack, ldr_ack}, 64'(0));
        end else begin
          e = q.pop_front();
          check("ack_who", {62'(0), core_ack, ldr_ack}, e.who ? 64'(1) : 64'(2));
          check("ack_err", e.who ? 64'(ldr_err) : 64'(core_err), 64'(e.err));
          check("ack_cycle", 64'(cyc), 64'(e.ack_cyc));
          check("rdata", 64'(rdata), 64'(e.rdata));
        end
      end
    end
  end

  // Push the expectation and raise the request; called at a negedge while idle.
  task automatic issue(input logic who, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic sel, input logic err,
                       input int ws_i, input logic [31:0] srd, input int lat);
    exp_t x;
    ws = ws_i;
    slv_rdata = srd;
    if (!we && !err) model_rdata = srd;
    x.who = who; x.we = we; x.addr = addr; x.wdata = wdata;
    x.rdata = model_rdata; x.sel = sel; x.err = err; x.ack_cyc = cyc + lat;
    q.push_back(x);
    if (who) begin
      ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
    end else begin
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    end
  endtask

  task automatic wait_acks(input int n, input int limit);
    int got;
    int t;
    got = 0;
    t = 0;
    while (got < n && t < limit) begin
      @(negedge clk);
      t++;
      if (core_ack) got++;
      if (ldr_ack) got++;
    end
    if (got < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_wait: got %0d acks expected %0d", got, n);
    end
    core_req = 1'b0;
    ldr_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
    bus_ready = 0; bus_rdata = '0;
    #1;
    check("rst_bus_valid", 64'(bus_valid), 64'(0));
    check("rst_acks", {60'(0), core_ack, ldr_ack, core_err, ldr_err}, 64'(0));
    check("rst_ctrl", {61'(0), bus_we, bus_sel, owner}, 64'(0));
    check("rst_addr", 64'(bus_addr), 64'(0));
    check("rst_wdata", 64'(bus_wdata), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Both requesting from reset: core, loader, core, loader, 3 cycles apart.
    @(negedge clk);
    issue(1'b0, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 0, 32'h1111_2222, 2);
    issue(1'b1, 1'b1, 32'h1000_0010, 32'h77, 1'b1, 1'b0, 0, 32'h1111_2222, 5);
    issue(1'b0, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, 0, 32'h1111_2222, 8);
    issue(1'b1, 1'b1, 32'h1000_0010, 32'h77, 1'b1, 1'b0, 0, 32'h1111_2222, 11);
    wait_acks(4, 40);

    // Core read, two wait states.
    @(negedge clk);
    issue(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 2, 32'hDEAD_BEEF, 4);
    wait_acks(1, 20);

    // Loader write to UART, immediate ready.
    @(negedge clk);
    issue(1'b1, 1'b1, 32'h1000_0000, 32'h0000_00A5, 1'b1, 1'b0, 0, 32'h0, 2);
    wait_acks(1, 20);

    // Core read never answered: timeout error, rdata unchanged.
    @(negedge clk);
    issue(1'b0, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 1'b1, 100000, 32'h5555_AAAA, 257);
    wait_acks(1, 300);

    // Ready arrives exactly when the count reaches TIMEOUT: ready wins.
    @(negedge clk);
    issue(1'b0, 1'b0, 32'h0000_0080, 32'h0, 1'b0, 1'b0, 255, 32'hCAFE_F00D, 257);
    wait_acks(1, 300);

    // Reset in the middle of a stalled transaction.
    @(negedge clk);
    issue(1'b0, 1'b0, 32'h0000_0048, 32'h0, 1'b0, 1'b0, 100000, 32'h0, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    core_req = 1'b0;
    #1;
    check("midrst_bus_valid", 64'(bus_valid), 64'(0));
    check("midrst_ack", {62'(0), core_ack, ldr_ack}, 64'(0));
    q.delete();
    model_rdata = '0;
    @(negedge clk);
    check("midrst_rdata", 64'(rdata), 64'(0));
    rst = 1'b0;

    // Tie after reset goes to the core first.
    @(negedge clk);
    issue(1'b0, 1'b0, 32'h0000_004C, 32'h0, 1'b0, 1'b0, 0, 32'h1234_5678, 2);
    issue(1'b1, 1'b1, 32'h1000_0020, 32'h3C, 1'b1, 1'b0, 0, 32'h1234_5678, 5);
    wait_acks(2, 20);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
